// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: TL store push, d-cache drain handshake, load forward lookup and status.
// slave = store buffer side, master = the environment driving it.
interface store_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 20
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              store_en;
  logic              store_isbyte;
  logic [ADDR_W-1:0] store_addr;
  logic [31:0]       store_data;

  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;

  logic              drain_valid;
  logic              drain_ready;
  logic [ADDR_W-1:0] drain_addr;
  logic [31:0]       drain_data;
  logic [3:0]        drain_be;

  logic              fwd_en;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_isbyte;
  logic              fwd_hit;
  logic              fwd_partial;
  logic [31:0]       fwd_data;

  modport slave (
    input  store_en, store_isbyte, store_addr, store_data,
    input  drain_ready,
    input  fwd_en, fwd_addr, fwd_isbyte,
    output full, empty, count, overflow,
    output drain_valid, drain_addr, drain_data, drain_be,
    output fwd_hit, fwd_partial, fwd_data
  );

  modport master (
    output store_en, store_isbyte, store_addr, store_data,
    output drain_ready,
    output fwd_en, fwd_addr, fwd_isbyte,
    input  full, empty, count, overflow,
    input  drain_valid, drain_addr, drain_data, drain_be,
    input  fwd_hit, fwd_partial, fwd_data
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer with byte-enabled drain and store-to-load forwarding.
// Define STORE_BUFFER_COALESCE_EN to merge same-word pushes into the youngest entry.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned WA     = ADDR_W - 2;
  localparam int unsigned NLANES = DATA_W / 8;

  logic [WA-1:0]     addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [NLANES-1:0] be_q   [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic              overflow_q;

  logic [WA-1:0]     push_waddr;
  logic [1:0]        push_lane;
  logic [NLANES-1:0] push_be;
  logic [DATA_W-1:0] push_data;
  logic              drain_valid, pop, merge, alloc, drop;

  assign push_waddr = sb.store_addr[ADDR_W-1:2];
  assign push_lane  = sb.store_addr[1:0];
  assign push_be    = sb.store_isbyte ? NLANES'(1) << push_lane : '1;
  assign push_data  = sb.store_isbyte ? DATA_W'(sb.store_data[7:0]) << {push_lane, 3'b000}
                                      : sb.store_data;

  assign drain_valid = (count_q != '0);
  assign pop         = drain_valid && sb.drain_ready;

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  assign tail_ptr = wptr_q - PW'(1);
  // count >= 2 guarantees the tail is never the entry being presented at drain.
  assign merge = sb.store_en && (count_q >= CW'(2)) && (addr_q[tail_ptr] == push_waddr);
`else
  assign merge = 1'b0;
`endif

  assign alloc = sb.store_en && !merge && ((count_q != CW'(DEPTH)) || pop);
  assign drop  = sb.store_en && !merge && !alloc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (alloc) begin
        addr_q[wptr_q] <= push_waddr;
        data_q[wptr_q] <= push_data;
        be_q[wptr_q]   <= push_be;
        wptr_q         <= wptr_q + PW'(1);
      end
`ifdef STORE_BUFFER_COALESCE_EN
      if (merge) begin
        for (int l = 0; l < NLANES; l++) begin
          if (push_be[l]) data_q[tail_ptr][8*l +: 8] <= push_data[8*l +: 8];
        end
        be_q[tail_ptr] <= be_q[tail_ptr] | push_be;
      end
`endif
      if (pop) rptr_q <= rptr_q + PW'(1);
      if (alloc && !pop)      count_q <= count_q + CW'(1);
      else if (!alloc && pop) count_q <= count_q - CW'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign sb.full        = (count_q == CW'(DEPTH));
  assign sb.empty       = !drain_valid;
  assign sb.count       = count_q;
  assign sb.overflow    = overflow_q;
  assign sb.drain_valid = drain_valid;
  assign sb.drain_addr  = drain_valid ? {addr_q[rptr_q], 2'b00} : '0;
  assign sb.drain_data  = drain_valid ? data_q[rptr_q] : '0;
  assign sb.drain_be    = drain_valid ? be_q[rptr_q] : '0;

  logic [NLANES-1:0] fwd_cov, fwd_req;
  logic [DATA_W-1:0] fwd_word, fwd_shift;
  logic [PW-1:0]     idx;
  logic              hit_raw;

  // Walk oldest to youngest so younger entries overwrite older lanes.
  always_comb begin
    fwd_cov  = '0;
    fwd_word = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx] == sb.fwd_addr[ADDR_W-1:2])) begin
        for (int l = 0; l < NLANES; l++) begin
          if (be_q[idx][l]) begin
            fwd_word[8*l +: 8] = data_q[idx][8*l +: 8];
            fwd_cov[l]         = 1'b1;
          end
        end
      end
    end
  end

  assign fwd_req   = sb.fwd_isbyte ? NLANES'(1) << sb.fwd_addr[1:0] : '1;
  assign hit_raw   = ((fwd_cov & fwd_req) == fwd_req);
  assign fwd_shift = fwd_word >> {sb.fwd_addr[1:0], 3'b000};

  assign sb.fwd_hit     = sb.fwd_en && hit_raw;
  assign sb.fwd_partial = sb.fwd_en && !hit_raw && ((fwd_cov & fwd_req) != '0);
  assign sb.fwd_data    = !(sb.fwd_en && hit_raw) ? '0 :
                          sb.fwd_isbyte ? DATA_W'(fwd_shift[7:0]) : fwd_word;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then random traffic vs a queue model.
module tb_store_buffer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 20;

  typedef struct {
    logic [ADDR_W-3:0] wa;
    logic [31:0]       data;
    logic [3:0]        be;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) sb ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  ent_t mq[$];
  bit   movf;
  int   nvec = 0;
  int   nmis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_fwd(output logic h, output logic p, output logic [31:0] d);
    logic [3:0]  req, got;
    logic [31:0] w, sh;
    got = '0;
    w   = '0;
    h   = 1'b0;
    p   = 1'b0;
    d   = '0;
    if (sb.fwd_en) begin
      req = sb.fwd_isbyte ? (4'b0001 << sb.fwd_addr[1:0]) : 4'hF;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].wa == sb.fwd_addr[ADDR_W-1:2]) begin
          for (int l = 0; l < 4; l++) begin
            if (req[l] && !got[l] && mq[i].be[l]) begin
              w[8*l +: 8] = mq[i].data[8*l +: 8];
              got[l]      = 1'b1;
            end
          end
        end
      end
      h  = (got == req);
      p  = (got != 4'h0) && !h;
      sh = w >> (8 * sb.fwd_addr[1:0]);
      d  = sb.fwd_isbyte ? {24'h0, sh[7:0]} : w;
    end
  endtask

  task automatic check_all();
    logic        eh, ep;
    logic [31:0] ed;
    check("count", sb.count, mq.size());
    check("full", sb.full, mq.size() == DEPTH);
    check("empty", sb.empty, mq.size() == 0);
    check("overflow", sb.overflow, movf);
    check("drain_valid", sb.drain_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("drain_addr", sb.drain_addr, {mq[0].wa, 2'b00});
      check("drain_data", sb.drain_data, mq[0].data);
      check("drain_be", sb.drain_be, mq[0].be);
    end
    model_fwd(eh, ep, ed);
    check("fwd_hit", sb.fwd_hit, eh);
    check("fwd_partial", sb.fwd_partial, ep);
    if (eh) check("fwd_data", sb.fwd_data, ed);
  endtask

  // Applies the spec rules to the pre-edge state using the inputs held across the edge.
  task automatic model_step();
    bit   pop, merged;
    ent_t e, t;
    pop    = (mq.size() > 0) && sb.drain_ready;
    merged = 1'b0;
    if (sb.store_en) begin
      e.wa = sb.store_addr[ADDR_W-1:2];
      if (sb.store_isbyte) begin
        e.be   = 4'b0001 << sb.store_addr[1:0];
        e.data = {24'h0, sb.store_data[7:0]} << (8 * sb.store_addr[1:0]);
      end else begin
        e.be   = 4'hF;
        e.data = sb.store_data;
      end
`ifdef STORE_BUFFER_COALESCE_EN
      if (mq.size() >= 2 && mq[mq.size()-1].wa == e.wa) begin
        t = mq[mq.size()-1];
        for (int l = 0; l < 4; l++) if (e.be[l]) t.data[8*l +: 8] = e.data[8*l +: 8];
        t.be |= e.be;
        mq[mq.size()-1] = t;
        merged = 1'b1;
      end
`endif
    end
    if (pop) void'(mq.pop_front());
    if (sb.store_en && !merged) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else movf = 1'b1;
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_store(input bit en, input bit isb, input logic [19:0] a, input logic [31:0] d);
    sb.store_en     = en;
    sb.store_isbyte = isb;
    sb.store_addr   = a;
    sb.store_data   = d;
  endtask

  task automatic set_fwd(input bit en, input bit isb, input logic [19:0] a);
    sb.fwd_en     = en;
    sb.fwd_isbyte = isb;
    sb.fwd_addr   = a;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_store(0, 0, '0, '0);
    set_fwd(1, 0, 20'h00700);
    sb.drain_ready = 1'b0;
    #2;
    mq.delete();
    movf = 1'b0;
    check_all();
    check("rst_drain_addr", sb.drain_addr, 0);
    check("rst_drain_data", sb.drain_data, 0);
    check("rst_drain_be", sb.drain_be, 0);
    check("rst_fwd_data", sb.fwd_data, 0);
    @(negedge clk);
    rst = 1'b1;
    set_fwd(0, 0, '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    sb.drain_ready = 1'b0;
    set_store(0, 0, '0, '0);
    set_fwd(0, 0, '0);
    do_reset();

    // Single word store, held while stalled, then drained.
    set_store(1, 0, 20'h00104, 32'hDEADBEEF);
    cycle();
    set_store(0, 0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t1_addr", sb.drain_addr, 20'h00104);
      check("t1_be", sb.drain_be, 4'hF);
      check("t1_data", sb.drain_data, 32'hDEADBEEF);
      check("t1_count", sb.count, 1);
      cycle();
    end
    sb.drain_ready = 1'b1;
    cycle();
    sb.drain_ready = 1'b0;
    #1 check("t1_empty", sb.empty, 1'b1);

    // Byte store lane placement.
    set_store(1, 1, 20'h00207, 32'h000000AB);
    cycle();
    set_store(0, 0, '0, '0);
    #1;
    check("t2_be", sb.drain_be, 4'h8);
    check("t2_data", sb.drain_data, 32'hAB000000);
    check("t2_addr", sb.drain_addr, 20'h00204);
    sb.drain_ready = 1'b1;
    cycle();
    sb.drain_ready = 1'b0;

    // Fill, overflow, then push+pop while full across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      set_store(1, 0, 20'h00800 + 20'(4 * i), 32'h1000 + 32'(i));
      cycle();
    end
    #1 check("t3_full", sb.full, 1'b1);
    set_store(1, 0, 20'h00900, 32'hBAD0BAD0);
    cycle();
    set_store(0, 0, '0, '0);
    #1;
    check("t3_overflow", sb.overflow, 1'b1);
    check("t3_count_drop", sb.count, 4);
    sb.drain_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_store(1, 0, 20'h00A00 + 20'(4 * i), 32'h2000 + 32'(i));
      cycle();
      #1 check("t3_count_pushpop", sb.count, 4);
    end
    set_store(0, 0, '0, '0);
    for (int i = 0; i < 4; i++) cycle();
    sb.drain_ready = 1'b0;

    // Forwarding merge across a word and a younger byte store.
    do_reset();
    set_store(1, 0, 20'h00300, 32'h11223344);
    cycle();
    set_store(1, 1, 20'h00301, 32'h00000055);
    cycle();
    set_store(0, 0, '0, '0);
    set_fwd(1, 0, 20'h00300);
    #1;
    check("t4_hit", sb.fwd_hit, 1'b1);
    check("t4_word", sb.fwd_data, 32'h11225544);
    set_fwd(1, 1, 20'h00302);
    #1 check("t4_byte", sb.fwd_data, 32'h00000022);
    cycle();

    // Partial coverage and miss.
    do_reset();
    set_store(1, 1, 20'h00401, 32'h00000055);
    cycle();
    set_store(0, 0, '0, '0);
    set_fwd(1, 0, 20'h00400);
    #1;
    check("t5_partial", sb.fwd_partial, 1'b1);
    check("t5_nohit", sb.fwd_hit, 1'b0);
    set_fwd(1, 0, 20'h00500);
    #1;
    check("t5_miss_hit", sb.fwd_hit, 1'b0);
    check("t5_miss_partial", sb.fwd_partial, 1'b0);
    cycle();

    // Same-word byte stores following a word store at the tail.
    do_reset();
    set_store(1, 0, 20'h00900, 32'h99999999);
    cycle();
    set_store(1, 0, 20'h00600, 32'hA0B0C0D0);
    cycle();
    set_store(1, 1, 20'h00601, 32'h00000011);
    cycle();
    set_store(1, 1, 20'h00602, 32'h00000022);
    cycle();
    set_store(0, 0, '0, '0);
    set_fwd(1, 0, 20'h00600);
    #1;
`ifdef STORE_BUFFER_COALESCE_EN
    check("t6_count", sb.count, 2);
`else
    check("t6_count", sb.count, 4);
`endif
    check("t6_hit", sb.fwd_hit, 1'b1);
    check("t6_data", sb.fwd_data, 32'hA02211D0);
    cycle();

    // Random traffic against the queue model, with one reset mid-stream.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      set_store($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                20'h00700 + 20'($urandom_range(0, 11)), $urandom);
      set_fwd($urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1,
              20'h00700 + 20'($urandom_range(0, 11)));
      sb.drain_ready = $urandom_range(0, 99) < 40;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
